// File: rtl/shared_mem_scheduler.sv
// Round-robin scheduler that shares one single-port SRAM bank among Req_Width
// requesters, with optional short lock bursts and one-hot routed read returns.
module shared_mem_scheduler #(
  parameter int Req_Width  = 10,
  parameter int Addr_Width = 8,
  parameter int Data_Width = 16,
  parameter int Max_Burst  = 4,
  parameter int Rd_Latency = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [Req_Width-1:0]             req,
  input  logic [Req_Width-1:0]             lock,
  input  logic [Req_Width-1:0]             we,
  input  logic [Req_Width*Addr_Width-1:0]  addr,
  input  logic [Req_Width*Data_Width-1:0]  wdata,
  output logic [Req_Width-1:0]             gnt,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [Addr_Width-1:0]            mem_addr,
  output logic [Data_Width-1:0]            mem_wdata,
  input  logic [Data_Width-1:0]            mem_rdata,
  output logic [Req_Width-1:0]             rd_valid,
  output logic [Data_Width-1:0]            rd_data
);

  localparam int Idx_Width = $clog2(Req_Width);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t                 state_reg, state_next;
  logic [Req_Width-1:0]   ptr_reg, ptr_next;
  logic [Idx_Width-1:0]   owner_reg, owner_next;
  logic [3:0]             burst_cnt_reg, burst_cnt_next;

  logic [Idx_Width-1:0]   ptr_idx;
  logic [Idx_Width:0]     pos;
  logic                   rr_found;
  logic [Idx_Width-1:0]   rr_idx;
  logic                   lock_hold;
  logic                   acc;
  logic [Idx_Width-1:0]   acc_idx;
  logic [Req_Width-1:0]   gnt_raw;
  logic [Req_Width-1:0]   ptr_adv;
  logic [Req_Width-1:0]   rd_id;

  logic [Rd_Latency:0][Req_Width-1:0] rd_pipe_reg;

  always_comb begin
    ptr_idx = '0;
    for (int k = 0; k < Req_Width; k++) begin
      if (ptr_reg[k]) ptr_idx = Idx_Width'(k);
    end
  end

  // Scan upward from the pointer, wrapping at Req_Width rather than 2**Idx_Width.
  always_comb begin
    pos      = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < Req_Width; k++) begin
      pos = {1'b0, ptr_idx} + (Idx_Width+1)'(k);
      if (pos >= (Idx_Width+1)'(Req_Width)) pos = pos - (Idx_Width+1)'(Req_Width);
      if (!rr_found && req[pos[Idx_Width-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = pos[Idx_Width-1:0];
      end
    end
  end

  // A locked owner keeps the bank only while it still requests; otherwise
  // the round-robin choice takes over in the same cycle.
  always_comb begin
    lock_hold = (state_reg == LOCKED) && req[owner_reg];
    acc       = lock_hold ? 1'b1 : rr_found;
    acc_idx   = lock_hold ? owner_reg : rr_idx;
  end

  for (genvar gi = 0; gi < Req_Width; gi++) begin : g_onehot
    assign gnt_raw[gi] = acc && (acc_idx == Idx_Width'(gi));
    assign gnt[gi]     = rst && gnt_raw[gi];
    assign ptr_adv[gi] = (acc_idx == Idx_Width'((gi + Req_Width - 1) % Req_Width));
    assign rd_id[gi]   = gnt_raw[gi] && !we[gi];
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    if (lock_hold) begin
      burst_cnt_next = 4'(burst_cnt_reg + 4'd1);
      if (!lock[owner_reg] || (burst_cnt_next >= 4'(Max_Burst))) begin
        state_next     = ARB;
        ptr_next       = ptr_adv;
        burst_cnt_next = '0;
      end
    end else if (acc) begin
      state_next     = ARB;
      ptr_next       = ptr_adv;
      burst_cnt_next = '0;
      if (lock[acc_idx] && (Max_Burst > 1)) begin
        state_next     = LOCKED;
        owner_next     = acc_idx;
        burst_cnt_next = 4'd1;
      end
    end else begin
      state_next     = ARB;
      burst_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ARB;
      ptr_reg       <= Req_Width'(1);
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (acc) begin
      mem_en    <= 1'b1;
      mem_we    <= we[acc_idx];
      mem_addr  <= addr[acc_idx*Addr_Width +: Addr_Width];
      mem_wdata <= wdata[acc_idx*Data_Width +: Data_Width];
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // The last pipe stage lines up with mem_rdata; the output register captures both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pipe_reg <= '0;
      rd_valid    <= '0;
      rd_data     <= '0;
    end else begin
      rd_pipe_reg <= {rd_pipe_reg[Rd_Latency-1:0], rd_id};
      rd_valid    <= rd_pipe_reg[Rd_Latency];
      rd_data     <= (|rd_pipe_reg[Rd_Latency]) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_shared_mem_scheduler.sv
// Directed bench for shared_mem_scheduler: gnt vector table plus hand-written
// read-latency, mixed-traffic and reset corner sequences.
module tb_shared_mem_scheduler;

  localparam int RW = 10;
  localparam int AW = 8;
  localparam int DW = 16;

  logic           clk;
  logic           rst;
  logic [RW-1:0]  req, lock, we;
  logic [RW*AW-1:0] addr;
  logic [RW*DW-1:0] wdata;
  logic [RW-1:0]  gnt;
  logic           mem_en, mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata, mem_rdata;
  logic [RW-1:0]  rd_valid;
  logic [DW-1:0]  rd_data;

  int checks = 0;
  int errors = 0;

  shared_mem_scheduler #(
    .Req_Width(RW), .Addr_Width(AW), .Data_Width(DW), .Max_Burst(4), .Rd_Latency(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: two-cycle read latency measured from the mem_en cycle.
  logic [DW-1:0] mem_model [256];
  logic [DW-1:0] r1, r2;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_model[mem_addr] <= mem_wdata;
    r1 <= mem_model[mem_addr];
    r2 <= r1;
  end
  assign mem_rdata = r2;

  typedef struct {
    logic [RW-1:0] req;
    logic [RW-1:0] lock;
    logic [RW-1:0] exp_gnt;
  } vec_t;
  vec_t vecs [23];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0; lock = '0; we = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    mem_model[8'h25] = 16'hBEEF;
    r1 = '0; r2 = '0;
    rst = 1'b0;
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

    vecs[0]  = '{10'h00D, 10'h000, 10'h001};
    vecs[1]  = '{10'h00D, 10'h000, 10'h004};
    vecs[2]  = '{10'h00D, 10'h000, 10'h008};
    vecs[3]  = '{10'h00D, 10'h000, 10'h001};
    vecs[4]  = '{10'h00D, 10'h000, 10'h004};
    vecs[5]  = '{10'h002, 10'h000, 10'h002};
    vecs[6]  = '{10'h203, 10'h000, 10'h200};
    vecs[7]  = '{10'h203, 10'h000, 10'h001};
    vecs[8]  = '{10'h203, 10'h000, 10'h002};
    vecs[9]  = '{10'h203, 10'h000, 10'h200};
    vecs[10] = '{10'h0C0, 10'h040, 10'h040};
    vecs[11] = '{10'h0C0, 10'h040, 10'h040};
    vecs[12] = '{10'h0C0, 10'h040, 10'h040};
    vecs[13] = '{10'h0C0, 10'h040, 10'h040};
    vecs[14] = '{10'h0C0, 10'h040, 10'h080};
    vecs[15] = '{10'h0C0, 10'h040, 10'h040};
    vecs[16] = '{10'h080, 10'h040, 10'h080};
    vecs[17] = '{10'h000, 10'h000, 10'h000};
    vecs[18] = '{10'h0C0, 10'h040, 10'h040};
    vecs[19] = '{10'h0C0, 10'h000, 10'h040};
    vecs[20] = '{10'h0C0, 10'h000, 10'h080};
    vecs[21] = '{10'h000, 10'h000, 10'h000};
    vecs[22] = '{10'h000, 10'h000, 10'h000};

    // Reset state
    tick();
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    #1;
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_mem_en", 32'(mem_en), 32'h0);

    // Arbitration / lock table
    for (int v = 0; v < 23; v++) begin
      req  = vecs[v].req;
      lock = vecs[v].lock;
      we   = '0;
      #1;
      $display("vec %0d req=%h lock=%h gnt=%h exp=%h", v, req, lock, gnt, vecs[v].exp_gnt);
      chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].exp_gnt));
      tick();
    end

    // Read latency: requester 3 reads 0x25
    do_reset();
    req = 10'h008; we = '0; addr[3*AW +: AW] = 8'h25;
    #1;
    chk("rdlat_gnt", 32'(gnt), 32'h008);
    tick();
    req = '0;
    chk("rdlat_mem_en", 32'(mem_en), 32'h1);
    chk("rdlat_mem_we", 32'(mem_we), 32'h0);
    chk("rdlat_mem_addr", 32'(mem_addr), 32'h25);
    for (int c = 1; c <= 5; c++) begin
      $display("rdlat cycle N+%0d rd_valid=%h rd_data=%h", c, rd_valid, rd_data);
      chk($sformatf("rdlat_valid_n%0d", c), 32'(rd_valid), (c == 4) ? 32'h008 : 32'h0);
      chk($sformatf("rdlat_data_n%0d", c), 32'(rd_data), (c == 4) ? 32'hBEEF : 32'h0);
      if (c == 2) chk("rdlat_mem_en_off", 32'(mem_en), 32'h0);
      tick();
    end

    // Mixed traffic: requester 0 writes, requester 2 reads the same address
    do_reset();
    req = 10'h005; we = 10'h001;
    addr[0*AW +: AW] = 8'h10; addr[2*AW +: AW] = 8'h10;
    wdata[0*DW +: DW] = 16'h1234;
    #1;
    chk("mix_gnt_w", 32'(gnt), 32'h001);
    tick();
    req = 10'h004; we = '0;
    #1;
    chk("mix_gnt_r", 32'(gnt), 32'h004);
    chk("mix_w_en", 32'(mem_en), 32'h1);
    chk("mix_w_we", 32'(mem_we), 32'h1);
    chk("mix_w_addr", 32'(mem_addr), 32'h10);
    chk("mix_w_wdata", 32'(mem_wdata), 32'h1234);
    tick();
    req = '0;
    chk("mix_r_en", 32'(mem_en), 32'h1);
    chk("mix_r_we", 32'(mem_we), 32'h0);
    chk("mix_r_addr", 32'(mem_addr), 32'h10);
    for (int c = 2; c <= 7; c++) begin
      $display("mix cycle N+%0d rd_valid=%h rd_data=%h", c, rd_valid, rd_data);
      chk($sformatf("mix_valid_n%0d", c), 32'(rd_valid), (c == 5) ? 32'h004 : 32'h0);
      chk($sformatf("mix_data_n%0d", c), 32'(rd_data), (c == 5) ? 32'h1234 : 32'h0);
      tick();
    end

    // Reset one cycle after a read accept
    do_reset();
    req = 10'h020; we = '0; addr[5*AW +: AW] = 8'h33;
    #1;
    chk("rmr_gnt", 32'(gnt), 32'h020);
    tick();
    req = 10'h060;
    chk("rmr_mem_en_pre", 32'(mem_en), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("rmr_gnt_in_rst", 32'(gnt), 32'h0);
    chk("rmr_mem_en_in_rst", 32'(mem_en), 32'h0);
    chk("rmr_rd_valid_in_rst", 32'(rd_valid), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    req = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      $display("post-reset cycle %0d gnt=%h mem_en=%h rd_valid=%h", c, gnt, mem_en, rd_valid);
      chk($sformatf("rmr_gnt_c%0d", c), 32'(gnt), 32'h0);
      chk($sformatf("rmr_mem_en_c%0d", c), 32'(mem_en), 32'h0);
      chk($sformatf("rmr_rd_valid_c%0d", c), 32'(rd_valid), 32'h0);
      tick();
    end
    req = 10'h060;
    #1;
    chk("rmr_ptr_restart", 32'(gnt), 32'h020);
    tick();
    req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_mem_scheduler.md
# shared_mem_scheduler

Sequences one single-port shared SRAM bank among `Req_Width` CGRA processing elements. Each cycle, a round-robin arbiter picks one request. An optional lock lets the winner keep the bank for a short burst. The scheduler registers the winning command onto the memory port and routes read data back to the issuing requester after the memory's fixed read latency. It sits between the PE load/store ports and the bank, upstream of the BIRA repair logic.

## Interface
- `Req_Width`, 10: number of requesters (2..16).
- `Addr_Width`, 8: bank address width.
- `Data_Width`, 16: data width.
- `Max_Burst`, 4: maximum consecutive grants to one locked owner (1..15).
- `Rd_Latency`, 1: cycles from `mem_en` to valid `mem_rdata` (1..4).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  Req_Width  per-requester access request.
- `lock`  in  Req_Width  requester asks to keep the bank after this access.
- `we`  in  Req_Width  1 = write, 0 = read.
- `addr`  in  Req_Width*Addr_Width  flattened; requester i at `[i*Addr_Width +: Addr_Width]`.
- `wdata`  in  Req_Width*Data_Width  flattened, same packing as `addr`.
- `gnt`  out  Req_Width  combinational one-hot grant; access accepted at the edge where `req[i]&gnt[i]`.
- `mem_en`, `mem_we`  out  1  registered bank command.
- `mem_addr`  out  Addr_Width  registered.
- `mem_wdata`  out  Data_Width  registered.
- `mem_rdata`  in  Data_Width  bank read data.
- `rd_valid`  out  Req_Width  registered one-hot; read data for requester i is valid.
- `rd_data`  out  Data_Width  registered copy of `mem_rdata` when any `rd_valid` bit is set, else 0.

## Operation
- **State:**
  - `ptr`: one-hot highest-priority index; resets to bit 0.
  - `owner`: index of the current lock owner.
  - `burst_cnt`: 4 bits.
  - FSM:
    - `ARB` (reset state): `gnt` = first set bit of `req` scanning from `ptr` upward with wrap to bit 0; `gnt`=0 if `req`=0.
    - `LOCKED`: `gnt` = `1<<owner` if `req[owner]`. If the owner drops `req`, fall back to `ARB` selection in the same cycle and go to `ARB`.
- **On accept to requester i:**
  - `ptr` <= bit (i+1) mod Req_Width, except when the accept is a locked continuation with the lock kept.
  - `ARB`→`LOCKED` when `lock[i]`=1 and `Max_Burst`>1; `owner`<=i; `burst_cnt`<=1.
  - In `LOCKED`, each accept increments `burst_cnt`.
  - Leave `LOCKED` for `ARB` when `lock[owner]`=0 at accept, or when `burst_cnt` reaches `Max_Burst`. On exit, `ptr` advances past the owner.
- **Command register:** on accept, `mem_en`<=1, `mem_we`<=`we[i]`, `mem_addr`/`mem_wdata` <= requester i slice. With no accept, `mem_en`<=0, `mem_we`<=0, and `mem_addr`/`mem_wdata` hold their values.
- **Read return:** a `Rd_Latency+1`-deep shift pipeline carries a one-hot ID for reads (0 for writes/idle). `rd_valid` is the pipeline output and is never asserted for writes.
- **Arbitration width:** pointer math is modulo `Req_Width`; wrap from bit `Req_Width-1` to bit 0.
- **Reset:** all outputs and state go to 0 (`ptr`=bit 0, `ARB`) immediately, independent of `clk`. In-flight reads are dropped, and no `rd_valid` appears after reset release.

## Timing
- `gnt` has zero latency from `req`/`lock`/state.
- Accept at edge N: `mem_*` valid in cycle N+1.
- Read data for an accept at edge N: `mem_rdata` arrives in cycle N+1+`Rd_Latency`, and is captured so that `rd_valid`/`rd_data` are valid in cycle N+2+`Rd_Latency`.
- Throughput: one access per cycle, sustained; back-to-back grants to different requesters have no bubble.
- A requester holds `req`, `we`, `addr`, `wdata` stable until it sees `gnt`. In the accept cycle it may immediately present the next access.
- Starvation bound: without locks, a continuously requesting PE waits at most `Req_Width-1` cycles. With locks, it waits at most `(Req_Width-1)*Max_Burst` cycles.

## Test plan
- **Reset state:** `rst`=0 mid-run → `gnt`, `mem_en`, `rd_valid` all 0 immediately; after release, `req`=10'b0 → `gnt`=0 and `mem_en` stays 0.
- **Round-robin rotation:** `req` held at 10'b0000001101 from reset → `gnt` sequence 0x001, 0x004, 0x008, 0x001, 0x004…; `req`=10'b1000000011 after a grant to bit 1 → next `gnt`=0x200, then 0x001 (wrap).
- **Lock burst:** `req`=10'b0011000000, `lock[6]`=1 held, `Max_Burst`=4 → `gnt`=0x040 for exactly 4 cycles, then 0x080. Dropping `req[6]` in the 2nd burst cycle → `gnt`=0x080 that same cycle.
- **Read latency:** `Rd_Latency`=2, requester 3 reads addr 0x25 accepted at edge N → `mem_en`=1, `mem_we`=0, `mem_addr`=0x25 in N+1; memory returns 0xBEEF in cycle N+3 → `rd_valid`=0x008 and `rd_data`=0xBEEF in N+4, for one cycle only.
- **Mixed traffic:** requester 0 writes 0x1234 to 0x10 while requester 2 reads 0x10, both requesting in the same cycle → write issues first, read next cycle; `rd_valid`=0x004 returns 0x1234; no `rd_valid` is generated for the write.
- **Reset mid-read:** assert `rst` one cycle after a read accept → no `rd_valid` pulse ever appears for that read, and `ptr` restarts at bit 0.
